alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_decode.sv | 67 ++++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the RV R-type ALU pipe: opcode/funct7 constants and
// the internal operation enumeration produced by alu_decode.
package alu_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_32    = 7'b0111011;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_SHADD = 7'b0010000;
  localparam logic [6:0] F7_ADDUW = 7'b0000100;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    ADD,
    SUB,
    SLL,
    SLT,
    SLTU,
    XOR,
    SRL,
    SRA,
    OR,
    AND,
    SH1ADD,
    SH2ADD,
    SH3ADD,
    ADDW,
    SUBW,
    ADD_UW,
    SH1ADD_UW,
    SH2ADD_UW,
    SH3ADD_UW,
    ILLEGAL
  } alu_op_e;

  // Left-shift applied to operand a by the shift-and-add family.
  function automatic int unsigned shadd_amt(alu_op_e op);
    case (op)
      SH1ADD, SH1ADD_UW: return 1;
      SH2ADD, SH2ADD_UW: return 2;
      SH3ADD, SH3ADD_UW: return 3;
      default:           return 0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational R-type decoder: opcode/funct3/funct7 to alu_op_e.
// The OP_32 group only exists on 64-bit datapaths.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    op_c
);

  localparam bit RV64 = (XLEN == 64);

  always_comb begin
    op_c = ILLEGAL;
    if (opcode == OP) begin
      case (funct7)
        F7_BASE: begin
          case (funct3)
            3'b000:  op_c = ADD;
            3'b001:  op_c = SLL;
            3'b010:  op_c = SLT;
            3'b011:  op_c = SLTU;
            3'b100:  op_c = XOR;
            3'b101:  op_c = SRL;
            3'b110:  op_c = OR;
            default: op_c = AND;
          endcase
        end
        F7_ALT: begin
          case (funct3)
            3'b000:  op_c = SUB;
            3'b101:  op_c = SRA;
            default: op_c = ILLEGAL;
          endcase
        end
        F7_SHADD: begin
          case (funct3)
            3'b010:  op_c = SH1ADD;
            3'b100:  op_c = SH2ADD;
            3'b110:  op_c = SH3ADD;
            default: op_c = ILLEGAL;
          endcase
        end
        default: op_c = ILLEGAL;
      endcase
    end else if (RV64 && (opcode == OP_32)) begin
      case (funct7)
        F7_BASE:  op_c = (funct3 == 3'b000) ? ADDW   : ILLEGAL;
        F7_ALT:   op_c = (funct3 == 3'b000) ? SUBW   : ILLEGAL;
        F7_ADDUW: op_c = (funct3 == 3'b000) ? ADD_UW : ILLEGAL;
        F7_SHADD: begin
          case (funct3)
            3'b010:  op_c = SH1ADD_UW;
            3'b100:  op_c = SH2ADD_UW;
            3'b110:  op_c = SH3ADD_UW;
            default: op_c = ILLEGAL;
          endcase
        end
        default: op_c = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 holds the decoded op and operands,
// stage 2 holds the result. One op per cycle, strictly in order.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_op_e          dec_op_c;
  logic             s1_valid;
  alu_op_e          s1_op;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_ready_c;
  logic             s1_adv_c;

  logic [XLEN-1:0]  a_uw_c;
  logic [XLEN-1:0]  sum_c;
  logic [XLEN-1:0]  diff_c;
  logic [SHW-1:0]   shamt_c;
  logic [XLEN-1:0]  alu_res_c;

  function automatic logic [XLEN-1:0] sext32(logic [XLEN-1:0] v);
    return XLEN'($signed(v[31:0]));
  endfunction

  alu_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .op_c   (dec_op_c)
  );

  // Stage 2 frees up when empty or drained this cycle; stage 1 follows it.
  assign s2_ready_c = !out_valid || out_ready;
  assign s1_adv_c   = s1_valid && s2_ready_c;
  assign in_ready   = !s1_valid || s1_adv_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= ILLEGAL;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= dec_op_c;
        s1_a   <= a;
        s1_b   <= b;
        s1_tag <= in_tag;
      end
    end
  end

  // Execute on stage 1 contents; illegal ops yield zero.
  always_comb begin
    a_uw_c    = XLEN'(s1_a[31:0]);
    sum_c     = s1_a + s1_b;
    diff_c    = s1_a - s1_b;
    shamt_c   = s1_b[SHW-1:0];
    alu_res_c = '0;
    case (s1_op)
      ADD:       alu_res_c = sum_c;
      SUB:       alu_res_c = diff_c;
      SLL:       alu_res_c = s1_a << shamt_c;
      SLT:       alu_res_c = XLEN'($signed(s1_a) < $signed(s1_b));
      SLTU:      alu_res_c = XLEN'(s1_a < s1_b);
      XOR:       alu_res_c = s1_a ^ s1_b;
      SRL:       alu_res_c = s1_a >> shamt_c;
      SRA:       alu_res_c = XLEN'($signed(s1_a) >>> shamt_c);
      OR:        alu_res_c = s1_a | s1_b;
      AND:       alu_res_c = s1_a & s1_b;
      SH1ADD,
      SH2ADD,
      SH3ADD:    alu_res_c = (s1_a << shadd_amt(s1_op)) + s1_b;
      ADDW:      alu_res_c = sext32(sum_c);
      SUBW:      alu_res_c = sext32(diff_c);
      ADD_UW:    alu_res_c = a_uw_c + s1_b;
      SH1ADD_UW,
      SH2ADD_UW,
      SH3ADD_UW: alu_res_c = (a_uw_c << shadd_amt(s1_op)) + s1_b;
      default:   alu_res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      illegal   <= 1'b0;
    end else if (s2_ready_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= alu_res_c;
        out_tag <= s1_tag;
        illegal <= (s1_op == ILLEGAL);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, stall/reset
// sequences, a 32-bit instance for OP_32 rejection, and random ops vs. a model.
module tb_alu_pipe;

  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, illegal;
  logic [63:0]      a, b, result;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic             in_valid32, in_ready32, out_valid32, illegal32;
  logic [31:0]      a32, b32, result32;
  logic [6:0]       opcode32, funct7_32;
  logic [2:0]       funct3_32;
  logic [TAG_W-1:0] in_tag32, out_tag32;

  alu_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .illegal(illegal)
  );

  alu_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .opcode(opcode32), .funct3(funct3_32), .funct7(funct7_32),
    .in_tag(in_tag32), .out_valid(out_valid32), .out_ready(1'b1),
    .result(result32), .out_tag(out_tag32), .illegal(illegal32)
  );

  typedef struct {
    logic [63:0]      res;
    logic             ill;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[$];
  logic [16:0] enc_tab [0:18];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [63:0] cur_res;
  logic        cur_ill;
  bit          cur_lat;

  // Reference: results straight from the instruction definitions.
  function automatic logic [64:0] ref64(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [63:0] x,
                                        input logic [63:0] y);
    logic [63:0] lo_x, t, r;
    logic [5:0]  sh;
    logic        ill;
    lo_x = x & 64'h0000_0000_FFFF_FFFF;
    sh   = y[5:0];
    ill  = 1'b0;
    r    = 64'd0;
    case ({opc, f7, f3})
      {7'b0110011, 7'b0000000, 3'b000}: r = x + y;
      {7'b0110011, 7'b0000000, 3'b001}: r = x << sh;
      {7'b0110011, 7'b0000000, 3'b010}: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      {7'b0110011, 7'b0000000, 3'b011}: r = (x < y) ? 64'd1 : 64'd0;
      {7'b0110011, 7'b0000000, 3'b100}: r = x ^ y;
      {7'b0110011, 7'b0000000, 3'b101}: r = x >> sh;
      {7'b0110011, 7'b0000000, 3'b110}: r = x | y;
      {7'b0110011, 7'b0000000, 3'b111}: r = x & y;
      {7'b0110011, 7'b0100000, 3'b000}: r = x - y;
      {7'b0110011, 7'b0100000, 3'b101}: r = x[63] ? ~((~x) >> sh) : (x >> sh);
      {7'b0110011, 7'b0010000, 3'b010}: r = x * 64'd2 + y;
      {7'b0110011, 7'b0010000, 3'b100}: r = x * 64'd4 + y;
      {7'b0110011, 7'b0010000, 3'b110}: r = x * 64'd8 + y;
      {7'b0111011, 7'b0000000, 3'b000}: begin
        t = (x + y) & 64'h0000_0000_FFFF_FFFF;
        r = t[31] ? (t | 64'hFFFF_FFFF_0000_0000) : t;
      end
      {7'b0111011, 7'b0100000, 3'b000}: begin
        t = (x - y) & 64'h0000_0000_FFFF_FFFF;
        r = t[31] ? (t | 64'hFFFF_FFFF_0000_0000) : t;
      end
      {7'b0111011, 7'b0000100, 3'b000}: r = lo_x + y;
      {7'b0111011, 7'b0010000, 3'b010}: r = lo_x * 64'd2 + y;
      {7'b0111011, 7'b0010000, 3'b100}: r = lo_x * 64'd4 + y;
      {7'b0111011, 7'b0010000, 3'b110}: r = lo_x * 64'd8 + y;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%h required 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [TAG_W-1:0] t);
    opcode = opc; funct3 = f3; funct7 = f7; a = x; b = y; in_tag = t;
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rise.
  task automatic cycle(output bit acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual tag %0d result 0x%h, required no output",
                 out_tag, result);
      end else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
    if (acc) begin
      e.res = cur_res; e.ill = cur_ill; e.tag = in_tag;
      e.acc_cyc = cyc; e.chk_lat = cur_lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int budget = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && budget < 50) begin
      cycle(acc);
      budget++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
    repeat (3) cycle(acc);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_op(input int unsigned t);
    logic [16:0] enc;
    logic [64:0] m;
    logic [63:0] x, y;
    int unsigned k;
    k = $urandom_range(0, 22);
    if (k < 19) enc = enc_tab[k];
    else if (k == 19) enc = {7'b0110011, 7'b0000001, 3'($urandom_range(0, 7))};
    else enc = 17'($urandom);
    x = rnd64();
    y = rnd64();
    m = ref64(enc[16:10], enc[2:0], enc[9:3], x, y);
    cur_res = m[63:0];
    cur_ill = m[64];
    cur_lat = 1'b0;
    set_op(enc[16:10], enc[2:0], enc[9:3], x, y, TAG_W'(t));
  endtask

  initial begin
    bit acc;
    int tries;
    int sent;
    int c;
    bit pend;

    enc_tab = '{
      {7'b0110011, 7'b0000000, 3'b000}, {7'b0110011, 7'b0000000, 3'b001},
      {7'b0110011, 7'b0000000, 3'b010}, {7'b0110011, 7'b0000000, 3'b011},
      {7'b0110011, 7'b0000000, 3'b100}, {7'b0110011, 7'b0000000, 3'b101},
      {7'b0110011, 7'b0000000, 3'b110}, {7'b0110011, 7'b0000000, 3'b111},
      {7'b0110011, 7'b0100000, 3'b000}, {7'b0110011, 7'b0100000, 3'b101},
      {7'b0110011, 7'b0010000, 3'b010}, {7'b0110011, 7'b0010000, 3'b100},
      {7'b0110011, 7'b0010000, 3'b110}, {7'b0111011, 7'b0000000, 3'b000},
      {7'b0111011, 7'b0100000, 3'b000}, {7'b0111011, 7'b0000100, 3'b000},
      {7'b0111011, 7'b0010000, 3'b010}, {7'b0111011, 7'b0010000, 3'b100},
      {7'b0111011, 7'b0010000, 3'b110}
    };

    // Hand-computed vectors: {opcode, funct3, funct7, a, b, result, illegal}
    vt.push_back('{7'b0110011, 3'b110, 7'b0010000, 64'h1, 64'h10, 64'h18, 1'b0});
    vt.push_back('{7'b0111011, 3'b010, 7'b0010000, 64'hFFFF_FFFF_8000_0001, 64'h0, 64'h1_0000_0002, 1'b0});
    vt.push_back('{7'b0111011, 3'b000, 7'b0100000, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vt.push_back('{7'b0110011, 3'b000, 7'b0000001, 64'h5, 64'h7, 64'h0, 1'b1});
    vt.push_back('{7'b0110011, 3'b000, 7'b0000000, 64'h5, 64'h7, 64'hC, 1'b0});
    vt.push_back('{7'b0110011, 3'b101, 7'b0100000, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0});
    vt.push_back('{7'b0110011, 3'b101, 7'b0000000, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0});
    vt.push_back('{7'b0110011, 3'b010, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b0});
    vt.push_back('{7'b0110011, 3'b011, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0});
    vt.push_back('{7'b0111011, 3'b000, 7'b0000000, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vt.push_back('{7'b0111011, 3'b000, 7'b0000100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1_0000_0000, 1'b0});
    vt.push_back('{7'b0110011, 3'b001, 7'b0000000, 64'h1, 64'h3F, 64'h8000_0000_0000_0000, 1'b0});
    vt.push_back('{7'b0110011, 3'b000, 7'b0100000, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vt.push_back('{7'b0110011, 3'b100, 7'b0000000, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0});
    vt.push_back('{7'b0110011, 3'b110, 7'b0000000, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0});
    vt.push_back('{7'b0110011, 3'b111, 7'b0000000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0});
    vt.push_back('{7'b0110011, 3'b100, 7'b0010000, 64'h3, 64'h1, 64'hD, 1'b0});
    vt.push_back('{7'b0111011, 3'b110, 7'b0010000, 64'hFFFF_FFFF_0000_0002, 64'h0, 64'h10, 1'b0});
    vt.push_back('{7'b0111011, 3'b100, 7'b0010000, 64'h1_0000_0001, 64'h4, 64'h8, 1'b0});
    vt.push_back('{7'b0110011, 3'b001, 7'b0100000, 64'h9, 64'h9, 64'h0, 1'b1});

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_op(7'd0, 3'd0, 7'd0, 64'd0, 64'd0, '0);
    in_valid32 = 1'b0;
    a32 = '0; b32 = '0; opcode32 = '0; funct3_32 = '0; funct7_32 = '0; in_tag32 = '0;
    cur_res = '0; cur_ill = 1'b0; cur_lat = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 32-bit datapath: OP_32 is illegal, following ADD is unaffected.
    @(posedge clk);
    #1;
    in_valid32 = 1'b1; opcode32 = 7'b0111011; funct3_32 = 3'b000; funct7_32 = 7'b0000000;
    a32 = 32'd1; b32 = 32'd2; in_tag32 = TAG_W'(1);
    #1;
    chk("x32_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1;
    opcode32 = 7'b0110011; a32 = 32'd3; b32 = 32'd4; in_tag32 = TAG_W'(2);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    chk("x32_op32_valid", 64'(out_valid32), 64'd1);
    chk("x32_op32_illegal", 64'(illegal32), 64'd1);
    chk("x32_op32_result", 64'(result32), 64'd0);
    chk("x32_op32_tag", 64'(out_tag32), 64'd1);
    @(posedge clk);
    #1;
    chk("x32_add_valid", 64'(out_valid32), 64'd1);
    chk("x32_add_illegal", 64'(illegal32), 64'd0);
    chk("x32_add_result", 64'(result32), 64'd7);
    chk("x32_add_tag", 64'(out_tag32), 64'd2);
    @(posedge clk);
    #1;
    chk("x32_idle", 64'(out_valid32), 64'd0);

    // Vector table, back-to-back with out_ready high: latency exactly 2.
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      set_op(vt[i].opc, vt[i].f3, vt[i].f7, vt[i].x, vt[i].y, TAG_W'(i + 3));
      cur_res = vt[i].res; cur_ill = vt[i].ill; cur_lat = 1'b1;
      in_valid = 1'b1;
      tries = 0;
      do begin
        cycle(acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL table_accept: actual not accepted, required accept of vector %0d", i);
      end
    end
    drain();

    // Eight-op stream with the consumer stalled in cycles 3-6.
    sent = 0;
    c = 0;
    while (sent < 8 && c < 40) begin
      c++;
      out_ready = !(c >= 3 && c <= 6);
      set_op(7'b0110011, 3'b000, 7'b0000000, 64'(100 + sent), 64'(sent), TAG_W'(sent));
      cur_res = 64'(100 + 2 * sent); cur_ill = 1'b0; cur_lat = 1'b0;
      in_valid = 1'b1;
      #1;
      if (c <= 2) begin
        chk("stream_in_ready_open", 64'(in_ready), 64'd1);
      end else if (c <= 6) begin
        chk("stream_in_ready_held", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_tag", 64'(out_tag), 64'd0);
        chk("stall_result", result, 64'd100);
      end
      cycle(acc);
      if (acc) sent++;
    end
    chk("stream_sent", 64'(sent), 64'd8);
    drain();

    // Reset with two ops in flight: nothing from before reset may emerge.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_op(7'b0110011, 3'b000, 7'b0000000, 64'h5, 64'h5, TAG_W'(26 + i));
      cur_res = 64'hA; cur_ill = 1'b0; cur_lat = 1'b0;
      in_valid = 1'b1;
      cycle(acc);
    end
    in_valid = 1'b0;
    #1;
    chk("inflight_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_out_tag", 64'(out_tag), 64'd0);
    chk("async_rst_illegal", 64'(illegal), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      chk("no_stale_output", 64'(out_valid), 64'd0);
    end
    set_op(7'b0110011, 3'b111, 7'b0000000, 64'hFF, 64'h0F, TAG_W'(9));
    cur_res = 64'h0F; cur_ill = 1'b0; cur_lat = 1'b1;
    in_valid = 1'b1;
    cycle(acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    drain();

    // Random ops with random offer gaps and consumer back-pressure.
    sent = 0;
    c = 0;
    pend = 1'b0;
    while (sent < 300 && c < 5000) begin
      c++;
      if (!pend && $urandom_range(0, 3) != 0) begin
        rand_op(32'(sent));
        pend = 1'b1;
      end
      in_valid = pend;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
    end
    chk("random_sent", 64'(sent), 64'd300);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
